risc_datapath: RTL and testbench

//   Datapath end of the CPU control interface. Consumes the controller's strobes
//   (rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel) and returns opcode/zero.

---
 rtl/risc_pkg.sv | 15 +
 rtl/risc_alu.sv | 26 ++
 rtl/risc_datapath.sv | 77 +++++++
 tb/tb_risc_datapath.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared widths and opcode encodings for the RISC datapath and its ALU.
package risc_pkg;
  localparam int DWIDTH = 8;
  localparam int AWIDTH = 5;
  localparam int OPW    = 3;

  localparam logic [OPW-1:0] OP_HLT = 3'd0;
  localparam logic [OPW-1:0] OP_SKZ = 3'd1;
  localparam logic [OPW-1:0] OP_ADD = 3'd2;
  localparam logic [OPW-1:0] OP_AND = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_LDA = 3'd5;
  localparam logic [OPW-1:0] OP_STO = 3'd6;
  localparam logic [OPW-1:0] OP_JMP = 3'd7;
endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: result of opcode applied to accumulator (a) and memory data (b).
module risc_alu
  import risc_pkg::*;
#(
  parameter int DW = DWIDTH,
  parameter int OW = OPW
) (
  input  logic [OW-1:0] opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
);

  // Non-arithmetic opcodes pass the accumulator through; sums drop the carry.
  always_comb begin
    result = a;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_LDA:  result = b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/risc_datapath.sv
// RISC datapath: IR/AC/PC registers, ALU and memory interface driven by controller strobes.
// Optional sticky protocol checker enabled by defining RISC_DP_PROTOCOL_CHECK_EN.
module risc_datapath
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  input  logic              rd,
  input  logic              wr,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              halt,
  input  logic              data_e,
  input  logic              sel,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic [OPW-1:0]    opcode,
  output logic              zero,
  output logic [AWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] ac,
  output logic              proto_err
);

  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] alu_result;
  logic [AWIDTH-1:0] operand;

  assign opcode  = ir[DWIDTH-1 -: OPW];
  assign operand = ir[AWIDTH-1:0];

  risc_alu #(.DW(DWIDTH), .OW(OPW)) u_alu (
    .opcode (opcode),
    .a      (ac),
    .b      (mem_rdata),
    .result (alu_result)
  );

  // ALU sees the pre-edge opcode, so ld_ir and ld_ac together behave sequentially.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      ir <= '0;
      ac <= '0;
      pc <= '0;
    end else if (!halt) begin
      if (ld_ir && rd) ir <= mem_rdata;
      if (ld_ac)       ac <= alu_result;
      if (ld_pc)       pc <= operand;
      else if (inc_pc) pc <= pc + {{(AWIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign zero      = (ac == '0);
  assign mem_addr  = sel ? pc : operand;
  assign mem_wdata = data_e ? ac : '0;
  assign mem_we    = wr & data_e;

`ifdef RISC_DP_PROTOCOL_CHECK_EN
  logic proto_hit;
  logic proto_err_q;

  assign proto_hit = (rd & wr) | (wr & ~data_e) | (ld_ir & ~rd) | (ld_pc & inc_pc & ~halt);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_)           proto_err_q <= 1'b0;
    else if (proto_hit) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed scenarios plus randomized strobes vs a behavioural model.
module tb_risc_datapath;

`ifdef RISC_DP_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       rd = 0, wr = 0, ld_ir = 0, ld_ac = 0, ld_pc = 0, inc_pc = 0;
  logic       halt = 0, data_e = 0, sel = 0;
  logic [7:0] mem_rdata = '0;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [2:0] opcode;
  logic       zero;
  logic [4:0] pc;
  logic [7:0] ac;
  logic       proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Behavioural model state
  int m_ir, m_ac, m_pc;
  bit m_perr;

  risc_datapath dut (
    .clk(clk), .rst_(rst_), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .halt(halt), .data_e(data_e), .sel(sel),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .opcode(opcode), .zero(zero), .pc(pc), .ac(ac),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int alu_model(input int op, input int a, input int d);
    if (op == 2) return (a + d) % 256;
    if (op == 3) return a & d;
    if (op == 4) return a ^ d;
    if (op == 5) return d;
    return a;
  endfunction

  task automatic model_clear();
    m_ir = 0; m_ac = 0; m_pc = 0; m_perr = 0;
  endtask

  // Called right after each rising edge with the inputs that were applied before it.
  task automatic model_update();
    int old_op;
    if (rst_) begin
      model_clear();
      return;
    end
    if (CHK && ((rd && wr) || (wr && !data_e) || (ld_ir && !rd) || (ld_pc && inc_pc && !halt)))
      m_perr = 1;
    if (halt) return;
    old_op = m_ir / 32;
    if (ld_ac) m_ac = alu_model(old_op, m_ac, mem_rdata);
    if (ld_pc) m_pc = m_ir % 32;
    else if (inc_pc) m_pc = (m_pc + 1) % 32;
    if (ld_ir && rd) m_ir = mem_rdata;
  endtask

  task automatic set_in(input logic i_rd, i_wr, i_ld_ir, i_ld_ac, i_ld_pc, i_inc_pc,
                        i_halt, i_data_e, i_sel, input logic [7:0] d);
    rd = i_rd; wr = i_wr; ld_ir = i_ld_ir; ld_ac = i_ld_ac; ld_pc = i_ld_pc;
    inc_pc = i_inc_pc; halt = i_halt; data_e = i_data_e; sel = i_sel; mem_rdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic step(input logic i_rd, i_wr, i_ld_ir, i_ld_ac, i_ld_pc, i_inc_pc,
                      i_halt, i_data_e, i_sel, input logic [7:0] d);
    set_in(i_rd, i_wr, i_ld_ir, i_ld_ac, i_ld_pc, i_inc_pc, i_halt, i_data_e, i_sel, d);
    tick();
  endtask

  task automatic fetch_ir(input logic [7:0] d);
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, d);
  endtask

  // Compare process: every falling edge, DUT outputs against the model and current inputs.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("ac", ac, m_ac);
      chk("opcode", opcode, m_ir / 32);
      chk("zero", zero, m_ac == 0);
      chk("mem_addr", mem_addr, sel ? m_pc : m_ir % 32);
      chk("mem_wdata", mem_wdata, data_e ? m_ac : 0);
      chk("mem_we", mem_we, wr && data_e);
      chk("proto_err", proto_err, m_perr);
    end
  end

  initial begin
    model_clear();
    #12;
    rst_ = 1'b0;
    @(posedge clk); #2;
    cmp_en = 1'b1;

    // Fetch at PC=3
    step(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    chk("lit_pc3", pc, 3);
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 1, 8'hA5);
    #1; chk("lit_fetch_addr", mem_addr, 3);
    tick();
    chk("lit_opcode_lda", opcode, 5);

    // ALU: LDA F0, ADD 20, XOR 10
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, 8'hF0);
    chk("lit_ac_f0", ac, 8'hF0);
    fetch_ir(8'h40);
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h20);
    chk("lit_add", ac, 8'h10);
    chk("lit_add_zero", zero, 0);
    fetch_ir(8'h80);
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h10);
    chk("lit_xor", ac, 8'h00);
    chk("lit_xor_zero", zero, 1);

    // PC wrap and load priority
    fetch_ir(8'h1F);
    step(0, 0, 0, 0, 1, 0, 0, 0, 1, 8'h00);
    chk("lit_pc31", pc, 31);
    step(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    chk("lit_pc_wrap", pc, 0);
    fetch_ir(8'hE7);
    step(0, 0, 0, 0, 1, 1, 0, 0, 1, 8'h00);
    chk("lit_ld_pc_wins", pc, 7);

    // Store
    fetch_ir(8'hA0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h3C);
    fetch_ir(8'hC9);
    set_in(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    #1;
    chk("lit_sto_addr", mem_addr, 9);
    chk("lit_sto_wdata", mem_wdata, 8'h3C);
    chk("lit_sto_we", mem_we, 1);
    data_e = 1'b0;
    #1;
    chk("lit_sto_wdata_off", mem_wdata, 0);
    chk("lit_sto_we_off", mem_we, 0);
    tick();

    // Halt freezes AC/PC
    step(0, 0, 0, 1, 0, 1, 1, 0, 1, 8'h55);
    chk("lit_halt_ac", ac, 8'h3C);
    chk("lit_halt_pc", pc, 7);

    // Mid-cycle async reset, then protocol check
    rst_ = 1'b1; model_clear();
    #1;
    chk("lit_rst_ac", ac, 0);
    chk("lit_rst_pc", pc, 0);
    chk("lit_rst_opcode", opcode, 0);
    chk("lit_rst_zero", zero, 1);
    chk("lit_rst_perr", proto_err, 0);
    tick();
    rst_ = 1'b0;
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    chk("lit_perr_sticky", proto_err, CHK);
    rst_ = 1'b1; model_clear();
    #1; chk("lit_perr_clear", proto_err, 0);
    tick();
    rst_ = 1'b0;

    // Randomized strobes against the model
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] s;
      s = 9'($urandom);
      set_in(s[0], s[1] & s[8], s[2], s[3], s[4] & s[5], s[5], ($urandom_range(0, 7) == 0),
             s[7] | s[1], s[6], 8'($urandom));
      if (($urandom_range(0, 7) == 0)) mem_rdata = 8'h00;
      if ($urandom_range(0, 99) == 0) begin
        rst_ = 1'b1; model_clear();
      end else begin
        rst_ = 1'b0;
      end
      tick();
    end
    rst_ = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
